// File: rtl/me_window_mem_if.sv
// me_window_mem_if: load-stream, control and read-port signals between me_window_mem and its source/core.
// Latency: none, wiring only.
// Backpressure: pix_valid/pix_ready handshake on the load stream; the read port is never stalled.
// Ports (master = source/core side, slave = memory):
//   load_start, pix_in, pix_valid, release_win, rd_en, addr, amt   master -> slave
//   pix_ready, load_done, mem_ready, pixel_cpr_out, pixel_spr_out, rd_valid   slave -> master
interface me_window_mem_if #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
);
  localparam int PORT_WIDTH = MACRO_DIM + 1;
  localparam int STRIPS     = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
  localparam int DEPTH      = STRIPS * SEARCH_DIM;
  localparam int AW         = $clog2(DEPTH);

  logic                            load_start;
  logic [7:0]                      pix_in;
  logic                            pix_valid;
  logic                            pix_ready;
  logic                            load_done;
  logic                            mem_ready;
  logic                            release_win;
  logic                            rd_en;
  logic [AW-1:0]                   addr;
  logic [AW-1:0]                   amt;
  logic [MACRO_DIM-1:0][7:0]       pixel_cpr_out;
  logic [PORT_WIDTH-1:0][7:0]      pixel_spr_out;
  logic                            rd_valid;

  modport master (
    output load_start, pix_in, pix_valid, release_win, rd_en, addr, amt,
    input  pix_ready, load_done, mem_ready, pixel_cpr_out, pixel_spr_out, rd_valid
  );

  modport slave (
    input  load_start, pix_in, pix_valid, release_win, rd_en, addr, amt,
    output pix_ready, load_done, mem_ready, pixel_cpr_out, pixel_spr_out, rd_valid
  );
endinterface

// File: rtl/me_window_mem.sv
// me_window_mem: loads one macroblock plus one search window into banked RAM and serves column reads.
// Latency: read data and rd_valid one cycle after rd_en; load_done one cycle after the final pixel.
// Backpressure: pix_ready is high only while loading; reads are accepted every cycle in READY, else ignored.
// Ports: clk, rst (async active-high) and bus (me_window_mem_if.slave):
//   load stream  load_start, pix_in, pix_valid, pix_ready, load_done
//   control      mem_ready, release_win
//   read port    rd_en, addr, amt -> pixel_cpr_out, pixel_spr_out, rd_valid
module me_window_mem #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
) (
  input  logic           clk,
  input  logic           rst,
  me_window_mem_if.slave bus
);
  localparam int PORT_WIDTH = MACRO_DIM + 1;
  localparam int STRIPS     = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
  localparam int DEPTH      = STRIPS * SEARCH_DIM;
  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = $clog2(SEARCH_DIM > MACRO_DIM ? SEARCH_DIM : MACRO_DIM);
  localparam int BW         = $clog2(PORT_WIDTH);
  localparam int RW         = $clog2(MACRO_DIM);

  typedef enum logic [1:0] {IDLE, LOAD_CURR, LOAD_SRCH, READY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   row_q, col_q;
  logic [BW-1:0]   bank_q;          // search column mod PORT_WIDTH
  logic [AW-1:0]   base_q;          // strip * SEARCH_DIM, stepped instead of multiplied
  logic            loading, hs, col_end, last_curr, last_srch, rd_fire;
  logic            load_done_q, rd_valid_q;
  logic [AW-1:0]   srch_waddr;
  logic [BW-1:0]   amt_mod;
  logic [BW:0]     rot_sum;
  logic [MACRO_DIM-1:0][7:0]  cpr_rd, cpr_q;
  logic [PORT_WIDTH-1:0][7:0] spr_rd, rot_rd, spr_q;

  assign loading   = (state_q == LOAD_CURR) || (state_q == LOAD_SRCH);
  assign hs        = bus.pix_valid && loading;
  assign col_end   = (state_q == LOAD_CURR) ? (col_q == CW'(MACRO_DIM - 1))
                                            : (col_q == CW'(SEARCH_DIM - 1));
  assign last_curr = hs && (state_q == LOAD_CURR) && col_end && (row_q == CW'(MACRO_DIM - 1));
  assign last_srch = hs && (state_q == LOAD_SRCH) && col_end && (row_q == CW'(SEARCH_DIM - 1));
  assign rd_fire   = bus.rd_en && (state_q == READY);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.load_start) state_d = LOAD_CURR;
      LOAD_CURR: if (last_curr)      state_d = LOAD_SRCH;
      LOAD_SRCH: if (last_srch)      state_d = READY;
      READY: begin
        if (bus.load_start)       state_d = LOAD_CURR;
        else if (bus.release_win) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pix_ready = loading;
  assign bus.mem_ready = (state_q == READY);

  // ---------------- raster position counters ----------------
  // Counters sit at zero whenever not loading, so any entry into LOAD_CURR starts at pixel 0.
  // In LOAD_CURR bank/base also step, but col wraps before bank can reach PORT_WIDTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      bank_q <= '0;
      base_q <= '0;
    end else if (!loading || last_curr) begin
      row_q  <= '0;
      col_q  <= '0;
      bank_q <= '0;
      base_q <= '0;
    end else if (hs) begin
      if (col_end) begin
        row_q  <= row_q + 1'b1;
        col_q  <= '0;
        bank_q <= '0;
        base_q <= '0;
      end else begin
        col_q <= col_q + 1'b1;
        if (bank_q == BW'(PORT_WIDTH - 1)) begin
          bank_q <= '0;
          base_q <= base_q + AW'(SEARCH_DIM);
        end else begin
          bank_q <= bank_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) load_done_q <= 1'b0;
    else     load_done_q <= last_srch;
  end
  assign bus.load_done = load_done_q;

  // ---------------- banked storage ----------------
  // One RAM per bank, each with its own write enable and an asynchronous read that
  // feeds the single registered output stage below.
  assign srch_waddr = base_q + AW'(row_q);

  for (genvar c = 0; c < MACRO_DIM; c++) begin : g_cbank
    logic [7:0] mem [MACRO_DIM];
    always_ff @(posedge clk) begin
      if (hs && (state_q == LOAD_CURR) && (col_q == CW'(c)))
        mem[row_q[RW-1:0]] <= bus.pix_in;
    end
    assign cpr_rd[c] = mem[bus.addr[RW-1:0]];
  end

  for (genvar b = 0; b < PORT_WIDTH; b++) begin : g_sbank
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (hs && (state_q == LOAD_SRCH) && (bank_q == BW'(b)))
        mem[srch_waddr] <= bus.pix_in;
    end
    assign spr_rd[b] = mem[bus.addr];
  end

  // ---------------- read path ----------------
  // Output lane l takes bank (l + amt) mod PORT_WIDTH; both operands are below
  // PORT_WIDTH after the reduction, so one conditional subtract finishes the wrap.
  assign amt_mod = BW'(bus.amt % AW'(PORT_WIDTH));

  always_comb begin
    rot_rd  = '0;
    rot_sum = '0;
    for (int l = 0; l < PORT_WIDTH; l++) begin
      rot_sum = (BW+1)'(l) + {1'b0, amt_mod};
      if (rot_sum >= (BW+1)'(PORT_WIDTH)) rot_sum = rot_sum - (BW+1)'(PORT_WIDTH);
      rot_rd[l] = spr_rd[BW'(rot_sum)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      cpr_q      <= '0;
      spr_q      <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        cpr_q <= cpr_rd;
        spr_q <= rot_rd;
      end
    end
  end

  assign bus.rd_valid      = rd_valid_q;
  assign bus.pixel_cpr_out = cpr_q;
  assign bus.pixel_spr_out = spr_q;
endmodule

// File: tb/tb_me_window_mem.sv
// tb_me_window_mem: drives loads and reads into me_window_mem and compares against an image-level model.
// Latency: expects read data one cycle after rd_en and load_done one cycle after the final pixel.
// Backpressure: the pixel source honours pix_ready and counts accepted beats; reads are issued back to back.
module tb_me_window_mem;
  localparam int MD     = 16;
  localparam int SD     = 48;
  localparam int PW     = MD + 1;
  localparam int STRIPS = (SD + PW - 1) / PW;
  localparam int DEPTH  = STRIPS * SD;
  localparam int AW     = $clog2(DEPTH);
  localparam int TOTAL  = MD * MD + SD * SD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  me_window_mem_if #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) bus ();
  me_window_mem #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference images: current macroblock [row][col], search window [y][x].
  logic [7:0] cur_ref  [MD][MD];
  logic [7:0] srch_ref [SD][SD];

  // Lane l of a search read shows window column strip*PW + (l+amt) mod PW at row addr mod SD.
  function automatic int spr_col(int a, int m, int l);
    return (a / SD) * PW + ((l + m) % PW);
  endfunction

  function automatic bit spr_care(int a, int m, int l);
    return (a < DEPTH) && (spr_col(a, m, l) < SD);
  endfunction

  function automatic logic [7:0] spr_exp(int a, int m, int l);
    if (!spr_care(a, m, l)) return 8'h00;
    return srch_ref[a % SD][spr_col(a, m, l)];
  endfunction

  function automatic logic [7:0] pix_at(int idx);
    int j;
    if (idx < MD * MD) return cur_ref[idx / MD][idx % MD];
    j = idx - MD * MD;
    return srch_ref[j / SD][j % SD];
  endfunction

  task automatic fill_images(input bit rnd);
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        cur_ref[r][c] = rnd ? 8'($urandom) : 8'(r * 16 + c);
    for (int y = 0; y < SD; y++)
      for (int x = 0; x < SD; x++)
        srch_ref[y][x] = rnd ? 8'($urandom) : 8'(y + x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses load_start, streams pixels until TOTAL beats are accepted (or abort_at is
  // reached), then keeps offering data for 3 cycles to catch any over-acceptance.
  task automatic load_window(input bit gaps, input int abort_at, input int poke_at,
                             output int beats, output int dones, output int done_beat,
                             output int extra, output bit timeout);
    int cyc;
    bit acc;
    cyc = 0; beats = 0; dones = 0; done_beat = -1; extra = 0; timeout = 0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    while (beats < TOTAL && beats != abort_at && cyc < 20000) begin
      bus.pix_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_in     = pix_at(beats);
      bus.load_start = (beats == poke_at);
      acc = bus.pix_valid && bus.pix_ready;
      tick();
      if (acc) beats++;
      if (bus.load_done) begin
        dones++;
        if (done_beat < 0) done_beat = beats;
      end
      cyc++;
    end
    bus.load_start = 1'b0;
    timeout = (cyc >= 20000);
    if (beats != abort_at) begin
      bus.pix_valid = 1'b1;
      repeat (3) begin
        acc = bus.pix_valid && bus.pix_ready;
        tick();
        if (acc) extra++;
        if (bus.load_done) dones++;
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.load_start = 0; bus.pix_in = 0; bus.pix_valid = 0; bus.release_win = 0;
    bus.rd_en = 0; bus.addr = '0; bus.amt = '0;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (bus.pix_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.load_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: pix_ready=%b mem_ready=%b rd_valid=%b load_done=%b, required all 0",
               bus.pix_ready, bus.mem_ready, bus.rd_valid, bus.load_done);
    end
    checks++;
    if (bus.pixel_cpr_out !== '0 || bus.pixel_spr_out !== '0) begin
      errors++;
      $display("FAIL reset_data: cpr=%h spr=%h, required 0", bus.pixel_cpr_out, bus.pixel_spr_out);
    end
    rst = 1'b0;
    bus.rd_en = 1'b1;
    bus.addr  = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0 || bus.mem_ready !== 1'b0 || bus.pix_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_read cycle %0d: rd_valid=%b mem_ready=%b pix_ready=%b, required 0",
                 i, bus.rd_valid, bus.mem_ready, bus.pix_ready);
      end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_load(input string tag, input bit rnd, input bit gaps, input int poke_at);
    int beats, dones, done_beat, extra;
    bit timeout;
    fill_images(rnd);
    load_window(gaps, -1, poke_at, beats, dones, done_beat, extra, timeout);
    checks++;
    if (timeout || beats !== TOTAL || extra !== 0) begin
      errors++;
      $display("FAIL %s beats: accepted=%0d extra=%0d timeout=%b, required %0d extra 0",
               tag, beats, extra, timeout, TOTAL);
    end
    checks++;
    if (dones !== 1 || done_beat !== TOTAL) begin
      errors++;
      $display("FAIL %s load_done: pulses=%0d at beat %0d, required 1 at beat %0d", tag, dones, done_beat, TOTAL);
    end
    checks++;
    if (bus.mem_ready !== 1'b1 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready: mem_ready=%b pix_ready=%b, required 1/0", tag, bus.mem_ready, bus.pix_ready);
    end
  endtask

  task automatic test_directed_reads();
    // addr 3, amt 0: current row 3, search row 3 columns 0..16.
    bus.rd_en = 1'b1; bus.addr = AW'(3); bus.amt = AW'(0);
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.pixel_cpr_out[5] !== 8'h35) begin
      errors++;
      $display("FAIL dir_a3: rd_valid=%b cpr[5]=%h, required 1 and 35", bus.rd_valid, bus.pixel_cpr_out[5]);
    end
    for (int l = 0; l < PW; l++) begin
      checks++;
      if (bus.pixel_spr_out[l] !== 8'(3 + l)) begin
        errors++;
        $display("FAIL dir_a3 spr[%0d]: got %0d, required %0d", l, bus.pixel_spr_out[l], 3 + l);
      end
    end
    // Strip 1, row 7, with amt 5 and its alias 22.
    for (int k = 0; k < 2; k++) begin
      bus.addr = AW'(SD + 7);
      bus.amt  = (k == 0) ? AW'(5) : AW'(22);
      tick();
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.pixel_spr_out[0] !== 8'd29 || bus.pixel_spr_out[12] !== 8'd24) begin
        errors++;
        $display("FAIL dir_strip1 amt=%0d: rd_valid=%b spr[0]=%0d spr[12]=%0d, required 1, 29, 24",
                 bus.amt, bus.rd_valid, bus.pixel_spr_out[0], bus.pixel_spr_out[12]);
      end
      for (int l = 0; l < PW; l++) begin
        if (spr_care(SD + 7, int'(bus.amt), l)) begin
          checks++;
          if (bus.pixel_spr_out[l] !== spr_exp(SD + 7, int'(bus.amt), l)) begin
            errors++;
            $display("FAIL dir_strip1 amt=%0d spr[%0d]: got %h, required %h",
                     bus.amt, l, bus.pixel_spr_out[l], spr_exp(SD + 7, int'(bus.amt), l));
          end
        end
      end
    end
    bus.rd_en = 1'b0;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL dir_idle: rd_valid=%b, required 0", bus.rd_valid);
    end
  endtask

  task automatic test_random_reads(input string tag, input int n);
    int a, m;
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      m = $urandom_range(0, 255);
      bus.rd_en = 1'b1; bus.addr = AW'(a); bus.amt = AW'(m);
      tick();
      checks++;
      if (bus.rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s rd_valid read %0d: got %b, required 1", tag, i, bus.rd_valid);
      end
      if (a < MD) begin
        for (int c = 0; c < MD; c++) begin
          checks++;
          if (bus.pixel_cpr_out[c] !== cur_ref[a][c]) begin
            errors++;
            $display("FAIL %s cpr addr=%0d [%0d]: got %h, required %h", tag, a, c, bus.pixel_cpr_out[c], cur_ref[a][c]);
          end
        end
      end
      for (int l = 0; l < PW; l++) begin
        if (spr_care(a, m, l)) begin
          checks++;
          if (bus.pixel_spr_out[l] !== spr_exp(a, m, l)) begin
            errors++;
            $display("FAIL %s spr addr=%0d amt=%0d [%0d]: got %h, required %h",
                     tag, a, m, l, bus.pixel_spr_out[l], spr_exp(a, m, l));
          end
        end
      end
    end
    // With rd_en low the outputs must hold the last read.
    bus.rd_en = 1'b0;
    bus.addr  = AW'($urandom_range(0, DEPTH - 1));
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s hold rd_valid: got %b, required 0", tag, bus.rd_valid);
    end
    for (int l = 0; l < PW; l++) begin
      if (spr_care(a, m, l)) begin
        checks++;
        if (bus.pixel_spr_out[l] !== spr_exp(a, m, l)) begin
          errors++;
          $display("FAIL %s hold spr[%0d]: got %h, required %h", tag, l, bus.pixel_spr_out[l], spr_exp(a, m, l));
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    int beats, dones, done_beat, extra;
    bit timeout;
    fill_images(1'b1);
    load_window(1'b0, MD * MD + 100, -1, beats, dones, done_beat, extra, timeout);
    rst = 1'b1;
    #2;
    checks++;
    if (bus.pix_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.rd_valid !== 1'b0 || dones !== 0) begin
      errors++;
      $display("FAIL midload_reset: pix_ready=%b mem_ready=%b rd_valid=%b dones=%0d, required 0",
               bus.pix_ready, bus.mem_ready, bus.rd_valid, dones);
    end
    tick();
    rst = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL midload_idle: rd_valid=%b pix_ready=%b, required 0", bus.rd_valid, bus.pix_ready);
    end
    bus.rd_en = 1'b0;
    test_load("reload", 1'b1, 1'b0, -1);
    test_random_reads("reload_reads", 100);
  endtask

  task automatic test_release_cycle();
    int a, m;
    a = $urandom_range(0, MD - 1);
    m = $urandom_range(0, 255);
    bus.rd_en = 1'b1; bus.release_win = 1'b1; bus.addr = AW'(a); bus.amt = AW'(m);
    tick();
    bus.release_win = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.mem_ready !== 1'b0 || bus.pixel_cpr_out[0] !== cur_ref[a][0]) begin
      errors++;
      $display("FAIL release_read: rd_valid=%b mem_ready=%b cpr[0]=%h, required 1, 0, %h",
               bus.rd_valid, bus.mem_ready, bus.pixel_cpr_out[0], cur_ref[a][0]);
    end
    checks++;
    if (bus.pixel_spr_out[0] !== spr_exp(a, m, 0)) begin
      errors++;
      $display("FAIL release_spr: got %h, required %h", bus.pixel_spr_out[0], spr_exp(a, m, 0));
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: rd_valid=%b, required 0", bus.rd_valid);
    end
    bus.rd_en = 1'b0;
    // Second window from IDLE with a stray load_start mid-stream.
    test_load("second_window", 1'b1, 1'b1, 300);
    test_random_reads("second_reads", 100);
  endtask

  initial begin
    test_reset();
    test_load("pattern_load", 1'b0, 1'b0, -1);
    test_directed_reads();
    test_random_reads("pattern_reads", 50);
    test_load("gap_load", 1'b1, 1'b1, -1);
    test_random_reads("gap_reads", 200);
    test_reset_midload();
    test_release_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/me_window_mem.md
Name: me_window_mem

Overview:
- Memory-side responder for the `me` motion-estimation core.
- Accepts a raster pixel stream for one current macroblock and then one search window, and writes it into banked on-chip RAM.
- Answers the core's `addr`/`amt` read requests with a full column of current pixels and a rotated column of search pixels.
- Replaces the combinational BRAM model the ME bench uses; it is the synthesizable RAM front end that feeds `me`.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels; number of current-picture banks.
- SEARCH_DIM, 48, search-window edge in pixels.
- PORT_WIDTH, MACRO_DIM+1, derived localparam; number of search banks.
- STRIPS, ceil(SEARCH_DIM/PORT_WIDTH), derived localparam; 3 at defaults.
- DEPTH, STRIPS*SEARCH_DIM, derived localparam; search bank depth, 144 at defaults.
- AW, clog2(DEPTH), derived localparam; read address width, 8 at defaults.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- load_start  in  1  pulse; begins loading a new macroblock and search window
- pix_in  in  8  stream pixel
- pix_valid  in  1  pix_in is valid
- pix_ready  out  1  block accepts pix_in this cycle
- load_done  out  1  one-cycle pulse when the last search pixel is written
- mem_ready  out  1  level; memory is loaded and serving reads
- release_win  in  1  pulse; current window is consumed, return to idle
- rd_en  in  1  read request
- addr  in  AW  read address (row for current banks; strip*SEARCH_DIM+row for search banks)
- amt  in  AW  search bank rotation amount
- pixel_cpr_out  out  8 x MACRO_DIM  current column; element i = current bank i at addr
- pixel_spr_out  out  8 x PORT_WIDTH  search column; element l = search bank (l+amt) mod PORT_WIDTH at addr
- rd_valid  out  1  read data valid

Behaviour:
- Reset values: state IDLE, pix_ready=0, load_done=0, mem_ready=0, rd_valid=0, pixel_cpr_out all 0, pixel_spr_out all 0, all counters 0. RAM contents are not reset.
- State IDLE: on load_start go to LOAD_CURR and clear row/column counters.
- State LOAD_CURR: pix_ready=1. Each handshake (pix_valid & pix_ready) writes current pixel (row r, col c) to cbank[c][r]. Input order is raster, col fastest. After MACRO_DIM*MACRO_DIM beats, clear counters and go to LOAD_SRCH.
- State LOAD_SRCH: pix_ready=1. Raster beat (row y, col x) writes sbank[x mod PORT_WIDTH][(x div PORT_WIDTH)*SEARCH_DIM + y].
  - Division and modulo come from incremental counters: a bank counter wraps at PORT_WIDTH and increments the strip counter. No dividers.
  - The final beat, (SEARCH_DIM-1, SEARCH_DIM-1), pulses load_done in the cycle after the handshake and moves to READY.
  - Unwritten slots at defaults (strip 2, banks 14..16) are don't-care.
- State READY: mem_ready=1, pix_ready=0. release_win goes to IDLE next cycle. load_start in READY goes directly to LOAD_CURR.
- Read path:
  - Read latency is 1 cycle. If rd_en is high in READY at edge N, then at edge N+1 the outputs hold the addressed data and rd_valid=1.
  - Otherwise rd_valid=0 and the data outputs hold their last values.
  - Back-to-back reads are supported, one per cycle.
  - rd_en outside READY is ignored.
- Rotation: the effective amount is amt mod PORT_WIDTH, so any amt value is legal.
- Addresses: for an addr >= MACRO_DIM, pixel_cpr_out is don't-care. For an addr >= DEPTH, pixel_spr_out is don't-care. No error is flagged.
- Simultaneous events: release_win and rd_en in the same cycle still returns the read, and the state becomes IDLE. load_start during LOAD_* is ignored.
- Reset mid-load: the block returns to IDLE and the partial load is discarded. The source must restart from pixel 0.
- Storage: MACRO_DIM + PORT_WIDTH independent single-port-write, single-port-read 8-bit RAMs (BRAM-inferable), plus one registered output stage.

Test Plan:
- Reset then idle → pix_ready=0, mem_ready=0, rd_valid=0; rd_en=1 with addr=0 gives rd_valid=0 for 5 cycles.
- Load current pixels with value = r*16+c, then search pixels with value = (y+x)&0xFF, with continuous pix_valid → exactly 256+2304 beats accepted, load_done pulses once, then mem_ready=1.
- After that load, rd_en with addr=3 and amt=0 → one cycle later: pixel_cpr_out[5]=0x35, pixel_spr_out[l]=3+l for l=0..16, rd_valid=1.
- Same data, addr=48+7 (strip 1, row 7), amt=5 → pixel_spr_out[0]=7+17+5=29 and pixel_spr_out[12]=7+17+0=24 (bank 0 wrap); amt=22 gives identical output to amt=5.
- Random pix_valid gaps (about 50% duty) during the load → final RAM contents match the gap-free run for 200 random reads.
- Assert rst after 100 search beats, then reload with new data → no stale reads and correct contents; release_win then load_start cycles through a second window cleanly.
